// File: rtl/data_mem_arbiter.sv
// Purpose : two-port round-robin arbiter that sequences SETUP/STROBE/DONE accesses to a 32x8 data_memory.
// Latency : grant edge to ack high is 2 cycles; one access every 4 cycles at most.
// Backpress: a requester holds req/we/addr/wdata until its ack; the losing port simply waits in IDLE.
//
// Ports: clk/rst_n (async active-low); req*/we*/addr*/wdata* requester inputs;
//        ack*/rdata* requester results; mem_rd/mem_wr/mem_addr/mem_wdata/mem_rdata memory side.
module data_mem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;      // port owning the access in flight
    logic          we_l_q, we_l_d;    // latched write-enable of the grantee
    logic          prio_q, prio_d;    // port that wins the next tie
    logic          pick;              // port selected this cycle in IDLE
    logic          ack0_d, ack1_d;
    logic [DW-1:0] rdata0_d, rdata1_d;
    logic          mem_rd_d, mem_wr_d;
    logic [AW-1:0] mem_addr_d;
    logic [DW-1:0] mem_wdata_d;

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here appear one cycle later, i.e. the strobe computed
    // while in SETUP is visible during STROBE.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        we_l_d      = we_l_q;
        prio_d      = prio_q;
        pick        = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        rdata0_d    = rdata0;
        rdata1_d    = rdata1;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to prio; otherwise the lone requester wins.
                    pick        = (req0 && req1) ? prio_q : req1;
                    gnt_d       = pick;
                    we_l_d      = pick ? we1 : we0;
                    mem_addr_d  = pick ? addr1 : addr0;
                    mem_wdata_d = pick ? wdata1 : wdata0;
                    prio_d      = ~pick;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                mem_rd_d = ~we_l_q;
                mem_wr_d = we_l_q;
                state_d  = STROBE;
            end
            STROBE: begin
                // mem_rd is high during this cycle, so mem_rdata is valid now.
                if (!we_l_q) begin
                    if (gnt_q) rdata1_d = mem_rdata;
                    else       rdata0_d = mem_rdata;
                end
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            we_l_q    <= 1'b0;
            prio_q    <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            we_l_q    <= we_l_d;
            prio_q    <= prio_d;
            ack0      <= ack0_d;
            ack1      <= ack1_d;
            rdata0    <= rdata0_d;
            rdata1    <= rdata1_d;
            mem_rd    <= mem_rd_d;
            mem_wr    <= mem_wr_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Purpose : directed self-checking bench for data_mem_arbiter with a small 32x8 memory model.
// Latency : checks ack two cycles after grant and one access per four cycles.
// Backpress: requesters hold their inputs until ack, as the arbiter expects.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_rdata [2];

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(5), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata0    (rdata0),
        .rdata1    (rdata1),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: asynchronous read, write while mem_wr is high at a clock edge.
    logic [7:0] mem [32];
    bit         preloaded;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            mem[2] <= 8'h01;
            mem[3] <= 8'h33;
            preloaded <= 1'b1;
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [4:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // One isolated access starting from IDLE; checks every phase.
    task automatic access(input int p, input logic w, input logic [4:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input string tag);
        drive_port(p, 1'b1, w, a, d);
        @(negedge clk); // SETUP
        check({tag, "_setup_strb"}, {30'd0, mem_rd, mem_wr}, 32'd0);
        check({tag, "_setup_addr"}, {27'd0, mem_addr}, {27'd0, a});
        check({tag, "_setup_wdat"}, {24'd0, mem_wdata}, {24'd0, d});
        @(negedge clk); // STROBE
        check({tag, "_strobe_strb"}, {30'd0, mem_rd, mem_wr}, {30'd0, ~w, w});
        check({tag, "_strobe_ack"}, {30'd0, ack1, ack0}, 32'd0);
        check({tag, "_strobe_addr"}, {27'd0, mem_addr}, {27'd0, a});
        @(negedge clk); // DONE
        if (!w) exp_rdata[p] = exp_rd;
        check({tag, "_done_ack"}, {30'd0, ack1, ack0}, (p == 1) ? 32'd2 : 32'd1);
        check({tag, "_done_strb"}, {30'd0, mem_rd, mem_wr}, 32'd0);
        check({tag, "_done_addr"}, {27'd0, mem_addr}, {27'd0, a});
        check({tag, "_done_wdat"}, {24'd0, mem_wdata}, {24'd0, d});
        check({tag, "_rdata0"}, {24'd0, rdata0}, {24'd0, exp_rdata[0]});
        check({tag, "_rdata1"}, {24'd0, rdata1}, {24'd0, exp_rdata[1]});
        drive_port(p, 1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge clk); // IDLE
        check({tag, "_idle_ack"}, {30'd0, ack1, ack0}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_port(0, 1'b0, 1'b0, 5'd0, 8'd0);
        drive_port(1, 1'b0, 1'b0, 5'd0, 8'd0);
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;

        // Reset held with random requests.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_port(0, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
            drive_port(1, 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom));
        end
        @(negedge clk);
        check("rst_hold_outs", {ack1, ack0, rdata1, rdata0, mem_rd, mem_wr, mem_addr, mem_wdata}, 32'd0);
        drive_port(0, 1'b0, 1'b0, 5'd0, 8'd0);
        drive_port(1, 1'b0, 1'b0, 5'd0, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_outs", {ack1, ack0, rdata1, rdata0, mem_rd, mem_wr, mem_addr, mem_wdata}, 32'd0);

        // Read preloaded location, write then read back on the other port.
        access(0, 1'b0, 5'd2, 8'h00, 8'h01, "rd0_a2");
        access(1, 1'b1, 5'd5, 8'hA5, 8'h00, "wr1_a5");
        access(1, 1'b0, 5'd5, 8'h00, 8'hA5, "rd1_a5");

        // Reset in the STROBE cycle of a port 0 write (prio moves to 1 on grant).
        drive_port(0, 1'b1, 1'b1, 5'd7, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        check("mrst_pre_wr", {31'd0, mem_wr}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_wr_drop", {30'd0, mem_wr, mem_rd}, 32'd0);
        check("mrst_outs", {ack1, ack0, rdata1, rdata0, mem_addr, mem_wdata}, 32'd0);
        drive_port(0, 1'b0, 1'b0, 5'd0, 8'd0);
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("mrst_idle", {28'd0, ack1, ack0, mem_rd, mem_wr}, 32'd0);
        end

        // Contention: both requesting continuously; port 0 wins the first tie.
        drive_port(0, 1'b1, 1'b0, 5'd2, 8'h00);
        drive_port(1, 1'b1, 1'b0, 5'd3, 8'h00);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("cont_ack", {30'd0, ack1, ack0},
                  (k == 3 || k == 11) ? 32'd1 : ((k == 7 || k == 15) ? 32'd2 : 32'd0));
            if (k == 1)  check("cont_addr_g0", {27'd0, mem_addr}, 32'd2);
            if (k == 5)  check("cont_addr_g1", {27'd0, mem_addr}, 32'd3);
            if (k == 3)  check("cont_rdata0", {24'd0, rdata0}, 32'h01);
            if (k == 7)  check("cont_rdata1", {24'd0, rdata1}, 32'h33);
            if (k == 15) begin
                drive_port(0, 1'b0, 1'b0, 5'd0, 8'd0);
                drive_port(1, 1'b0, 1'b0, 5'd0, 8'd0);
            end
        end

        // Back-to-back on port 0; addr0 changes mid-access take effect only at the next grant.
        drive_port(0, 1'b1, 1'b0, 5'd2, 8'h00);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("b2b_ack", {30'd0, ack1, ack0}, (k == 3 || k == 7 || k == 11) ? 32'd1 : 32'd0);
            case (k)
                1: begin
                    check("b2b_addr_k1", {27'd0, mem_addr}, 32'd2);
                    addr0 = 5'd5;
                end
                2:  check("b2b_rd_k2", {27'd0, mem_addr, mem_rd}, {27'd0, 5'd2, 1'b1} >> 1 << 1 | 32'd1);
                3:  check("b2b_rdata_1", {24'd0, rdata0}, 32'h01);
                4:  check("b2b_addr_k4", {27'd0, mem_addr}, 32'd2);
                5: begin
                    check("b2b_addr_k5", {27'd0, mem_addr}, 32'd5);
                    addr0 = 5'd3;
                end
                7:  check("b2b_rdata_2", {24'd0, rdata0}, 32'hA5);
                9:  check("b2b_addr_k9", {27'd0, mem_addr}, 32'd3);
                11: begin
                    check("b2b_rdata_3", {24'd0, rdata0}, 32'h33);
                    check("b2b_rdata1", {24'd0, rdata1}, 32'h33);
                    drive_port(0, 1'b0, 1'b0, 5'd0, 8'd0);
                end
                default: ;
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
